// File: rtl/hilbert_pkg.sv
// rtl/hilbert_pkg.sv - shared widths, FSM states and saturation helper for the HilbertFilter datapath
package hilbert_pkg;

    localparam int SPEED_W    = 16;
    localparam int PHASE_W    = 19;
    localparam int SPEED_FRAC = 10;
    localparam int PROD_W     = SPEED_W + 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        MUL  = 2'd2
    } state_t;

    localparam logic signed [PROD_W-1:0] PHASE_MAX = PROD_W'((1 << (PHASE_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] PHASE_MIN = -PHASE_MAX - PROD_W'(1);

    function automatic logic signed [PHASE_W-1:0] sat_phase(input logic signed [PROD_W-1:0] v);
        if (v > PHASE_MAX)
            return PHASE_MAX[PHASE_W-1:0];
        else if (v < PHASE_MIN)
            return PHASE_MIN[PHASE_W-1:0];
        else
            return v[PHASE_W-1:0];
    endfunction

endpackage

// File: rtl/speed_ramp.sv
// rtl/speed_ramp.sv - combinational slew of the current speed toward the target
module speed_ramp
    import hilbert_pkg::*;
(
    input  logic signed [SPEED_W-1:0] target,
    input  logic signed [SPEED_W-1:0] cur,
    input  logic        [3:0]         ramplen,
    output logic signed [SPEED_W-1:0] next_cur
);

    localparam int DW = SPEED_W + 1;

    logic signed [DW-1:0] diff;
    logic signed [DW-1:0] step;

    // Arithmetic shift floors, so |step| <= |diff| and the result can never overshoot.
    always_comb begin
        diff = DW'(target) - DW'(cur);
        step = diff >>> ramplen;
        if (step == '0 && diff != '0)
            step = diff[DW-1] ? {DW{1'b1}} : DW'(1);
        next_cur = cur + $signed(step[SPEED_W-1:0]);
    end

endmodule

// File: rtl/speed2phase.sv
// rtl/speed2phase.sv - speed-to-phase synthesizer: slewed speed, scaled phase sample, wrapping accumulator
module speed2phase
    import hilbert_pkg::*;
#(
    parameter int unsigned KSCALE = 1608,
    parameter int unsigned KSHIFT = 8
)
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sample,
    input  logic                      speed_load,
    input  logic signed [SPEED_W-1:0] speed,
    input  logic        [3:0]         ramplen,
    output logic signed [PHASE_W-1:0] phase,
    output logic signed [PHASE_W-1:0] phase_acc,
    output logic                      ready,
    output logic                      busy
);

    state_t state;
    state_t state_nxt;
    logic   do_ramp;
    logic   do_mul;

    logic signed [SPEED_W-1:0] target;
    logic signed [SPEED_W-1:0] cur;
    logic signed [SPEED_W-1:0] ramp_target;
    logic signed [SPEED_W-1:0] cur_nxt;
    logic signed [PROD_W-1:0]  prod;
    logic signed [PHASE_W-1:0] phase_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample) state_nxt = RAMP;
            RAMP:    state_nxt = MUL;
            MUL:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        do_ramp = (state == RAMP);
        do_mul  = (state == MUL);
    end

    // A load landing on the RAMP edge itself still steers that ramp.
    assign ramp_target = speed_load ? speed : target;

    speed_ramp u_ramp (
        .target   (ramp_target),
        .cur      (cur),
        .ramplen  (ramplen),
        .next_cur (cur_nxt)
    );

    always_comb begin
        prod      = PROD_W'(cur) * $signed(PROD_W'(KSCALE));
        phase_nxt = sat_phase(prod >>> KSHIFT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            target    <= '0;
            cur       <= '0;
            phase     <= '0;
            phase_acc <= '0;
            ready     <= 1'b0;
        end else begin
            ready <= do_mul;
            if (speed_load)
                target <= speed;
            if (do_ramp)
                cur <= cur_nxt;
            if (do_mul) begin
                phase     <= phase_nxt;
                phase_acc <= phase_acc + phase_nxt;
            end
        end
    end

endmodule
